// File: rtl/uart_rx_drain_pkg.sv
// Shared types and constants for the UART receive-FIFO drain controller.
package uart_rx_drain_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      COLLECT = 2'b01,
      PRESENT = 2'b11
   } state_e;

   localparam int unsigned WORD_BYTES = 4;

   // Bit positions inside irq_stat
   localparam int unsigned PE = 0;
   localparam int unsigned FE = 1;
   localparam int unsigned OV = 2;

endpackage

// File: rtl/uart_rx_drain_ctrl_if.sv
// Word stream from the drain controller to the APB/DMA side.
interface uart_rx_drain_ctrl_if;

   logic        m_valid;
   logic        m_ready;
   logic [31:0] m_data;
   logic [2:0]  m_bcnt;
   logic        m_err;

   modport master (
      output m_valid,
      output m_data,
      output m_bcnt,
      output m_err,
      input  m_ready
   );

   modport slave (
      input  m_valid,
      input  m_data,
      input  m_bcnt,
      input  m_err,
      output m_ready
   );

endinterface

// File: rtl/uart_rx_word_packer.sv
// Little-endian byte-to-word packer: lane registers, byte count and error tag.
module uart_rx_word_packer
   import uart_rx_drain_pkg::*;
(
   input  logic        pclk,
   input  logic        preset,
   input  logic        load,
   input  logic        clear,
   input  logic [7:0]  rx_byte,
   input  logic        bad,
   output logic [31:0] data,
   output logic [2:0]  bcnt,
   output logic        err
);

   logic [31:0] data_q, data_d;
   logic [2:0]  bcnt_q, bcnt_d;
   logic        err_q, err_d;
   logic        full;

   assign full = (bcnt_q >= 3'(WORD_BYTES));

   always_comb begin
      data_d = data_q;
      bcnt_d = bcnt_q;
      err_d  = err_q;
      if (clear) begin
         data_d = '0;
         bcnt_d = '0;
         err_d  = 1'b0;
      end else if (load && !full) begin
         // Lane select uses the low bits only; bcnt never exceeds 4.
         data_d[{bcnt_q[1:0], 3'b000} +: 8] = rx_byte;
         bcnt_d = bcnt_q + 3'd1;
         err_d  = err_q | bad;
      end
   end

   always_ff @(posedge pclk) begin
      if (preset) begin
         data_q <= '0;
         bcnt_q <= '0;
         err_q  <= 1'b0;
      end else begin
         data_q <= data_d;
         bcnt_q <= bcnt_d;
         err_q  <= err_d;
      end
   end

   assign data = data_q;
   assign bcnt = bcnt_q;
   assign err  = err_q;

endmodule

// File: rtl/uart_rx_drain_ctrl.sv
// Drains the UART receive FIFO into 32-bit words with timeout flush, error
// filtering/tagging and sticky interrupt status.
module uart_rx_drain_ctrl
   import uart_rx_drain_pkg::*;
#(
   parameter int unsigned TO_W      = 16,
   parameter int unsigned ERR_CNT_W = 8
) (
   input  logic                 pclk,
   input  logic                 preset,
   input  logic                 cfg_en,
   input  logic [TO_W-1:0]      cfg_timeout,
   input  logic                 cfg_err_drop,
   input  logic                 rx_ne,
   input  logic [7:0]           rx_data,
   input  logic                 rx_pe,
   input  logic                 rx_fe,
   input  logic                 rx_ov,
   output logic                 ctrl_data_rd,
   uart_rx_drain_ctrl_if.master m_if,
   output logic [2:0]           irq_stat,
   input  logic [2:0]           irq_clr,
   output logic [ERR_CNT_W-1:0] err_cnt
);

   state_e                state_q, state_d;
   logic [TO_W-1:0]       to_cnt_q, to_cnt_d;
   logic [2:0]            irq_q, irq_d;
   logic [ERR_CNT_W-1:0]  err_cnt_q, err_cnt_d;

   logic        bad, pop, keep, drop, handshake, pk_clear, timed_out;
   logic [TO_W:0] to_inc;
   logic [31:0] pk_data;
   logic [2:0]  pk_bcnt;
   logic        pk_err;

   assign bad       = rx_pe | rx_fe;
   assign pop       = cfg_en & rx_ne & ((state_q == IDLE) | (state_q == COLLECT));
   assign keep      = pop & ~(bad & cfg_err_drop);
   assign drop      = pop & bad & cfg_err_drop;
   assign handshake = (state_q == PRESENT) & m_if.m_ready;
   assign pk_clear  = ~cfg_en | handshake;

   // Compare the count including the current idle cycle, so a timeout of T
   // flushes on the (T)th consecutive idle cycle and 0 flushes on the first.
   assign to_inc    = {1'b0, to_cnt_q} + (TO_W+1)'(1);
   assign timed_out = (to_inc >= {1'b0, cfg_timeout});

   always_comb begin
      state_d  = state_q;
      to_cnt_d = to_cnt_q;
      if (!cfg_en) begin
         state_d  = IDLE;
         to_cnt_d = '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (pop)  to_cnt_d = '0;
               if (keep) state_d  = COLLECT;
            end
            COLLECT: begin
               if (pop) begin
                  to_cnt_d = '0;
                  if (keep && (pk_bcnt == 3'(WORD_BYTES - 1))) state_d = PRESENT;
               end else begin
                  to_cnt_d = to_inc[TO_W-1:0];
                  if (timed_out) state_d = PRESENT;
               end
            end
            PRESENT: begin
               if (handshake) begin
                  state_d  = IDLE;
                  to_cnt_d = '0;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      // A set in the same cycle as its clear takes precedence.
      irq_d = irq_q & ~irq_clr;
      if (cfg_en) begin
         if (pop & rx_pe) irq_d[PE] = 1'b1;
         if (pop & rx_fe) irq_d[FE] = 1'b1;
         if (rx_ov)       irq_d[OV] = 1'b1;
      end
      err_cnt_d = err_cnt_q;
      if (drop && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
   end

   always_ff @(posedge pclk) begin
      if (preset) begin
         state_q   <= IDLE;
         to_cnt_q  <= '0;
         irq_q     <= '0;
         err_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         to_cnt_q  <= to_cnt_d;
         irq_q     <= irq_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   uart_rx_word_packer u_packer (
      .pclk    (pclk),
      .preset  (preset),
      .load    (keep),
      .clear   (pk_clear),
      .rx_byte (rx_data),
      .bad     (bad),
      .data    (pk_data),
      .bcnt    (pk_bcnt),
      .err     (pk_err)
   );

   assign ctrl_data_rd = pop;
   assign m_if.m_valid = (state_q == PRESENT);
   assign m_if.m_data  = pk_data;
   assign m_if.m_bcnt  = pk_bcnt;
   assign m_if.m_err   = pk_err;
   assign irq_stat     = irq_q;
   assign err_cnt      = err_cnt_q;

endmodule
